// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer arbiter: FSM states and port selects.
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } fb_state_e;

    localparam logic PORT_RD = 1'b0;
    localparam logic PORT_WR = 1'b1;

endpackage

// File: rtl/fb_addr_gen.sv
// Per-port burst address counter: advance on burst completion, wrap at end of
// frame (disabling the port), restart on vsync, and defer a vsync that lands
// while this port's burst is in flight until that burst completes.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 307200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              busy,   // this port owns the current burst
    input  logic              done,   // this port's burst completed
    output logic [ADDR_W-1:0] addr,
    output logic              en,
    output logic              wrap    // frame finished on this completion
);

    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
    logic              en_q, en_d;
    logic              pend_q, pend_d;

    assign addr_nxt = addr_q + STEP;

    // Next-state: a vsync (live or deferred) beats the advance on completion.
    always_comb begin
        addr_d = addr_q;
        en_d   = en_q;
        pend_d = pend_q;
        wrap   = 1'b0;
        if (done) begin
            if (vsync || pend_q) begin
                addr_d = '0;
                en_d   = 1'b1;
                pend_d = 1'b0;
            end else if (addr_nxt == FRAME_END) begin
                addr_d = '0;
                en_d   = 1'b0;
                wrap   = 1'b1;
            end else begin
                addr_d = addr_nxt;
            end
        end else if (vsync) begin
            if (busy) begin
                pend_d = 1'b1;
            end else begin
                addr_d = '0;
                en_d   = 1'b1;
                pend_d = 1'b0;
            end
        end
    end

    // Counter, enable and pending-vsync registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            en_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            en_q   <= en_d;
            pend_q <= pend_d;
        end
    end

    assign addr = addr_q;
    assign en   = en_q;

endmodule

// File: rtl/frame_buf_arbiter.sv
// Arbitrates SDRAM bursts between camera write FIFO and display read FIFO.
// Optional FB_PINGPONG_EN: double-buffered frames, bank bit in address MSB.
module frame_buf_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int LVL_W       = 10,
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 307200,
    parameter int RD_DEPTH    = 1024
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [LVL_W-1:0]  iWR_LEVEL,
    input  logic [LVL_W-1:0]  iRD_LEVEL,
    input  logic              iWR_VSYNC,
    input  logic              iRD_VSYNC,
    output logic              oCMD_VALID,
    output logic              oCMD_WRITE,
    output logic [ADDR_W-1:0] oCMD_ADDR,
    input  logic              iCMD_READY,
    input  logic              iBURST_DONE,
    output logic              oBUSY,
    output logic              oWR_BANK,
    output logic              oRD_BANK
);

    fb_state_e         state_q, state_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

    logic [ADDR_W-1:0] rd_addr, wr_addr, rd_cmd_addr, wr_cmd_addr;
    logic              rd_en, wr_en, rd_wrap_unused, wr_wrap;
    logic              rd_elig, wr_elig, rd_low, grant, grant_port;
    logic              rd_busy, wr_busy, rd_done, wr_done;

    assign rd_elig = rd_en && (32'(iRD_LEVEL) + 32'(BURST_LEN) <= 32'(RD_DEPTH));
    assign wr_elig = wr_en && (32'(iWR_LEVEL) >= 32'(BURST_LEN));
    assign rd_low  = 32'(iRD_LEVEL) < 32'(BURST_LEN);

    // Grant selection in IDLE: underflow guard, then round-robin on ties.
    always_comb begin
        grant      = 1'b0;
        grant_port = PORT_RD;
        if (state_q == ST_IDLE) begin
            if (rd_elig && rd_low) begin
                grant      = 1'b1;
                grant_port = PORT_RD;
            end else if (rd_elig && wr_elig) begin
                grant      = 1'b1;
                grant_port = ~last_q;
            end else if (rd_elig) begin
                grant      = 1'b1;
                grant_port = PORT_RD;
            end else if (wr_elig) begin
                grant      = 1'b1;
                grant_port = PORT_WR;
            end
        end
    end

    // The grant cycle counts as busy so a vsync there is deferred rather than
    // moving the address underneath the command being latched.
    assign rd_busy = (state_q != ST_IDLE && port_q == PORT_RD) || (grant && grant_port == PORT_RD);
    assign wr_busy = (state_q != ST_IDLE && port_q == PORT_WR) || (grant && grant_port == PORT_WR);
    assign rd_done = (state_q == ST_WAIT) && iBURST_DONE && (port_q == PORT_RD);
    assign wr_done = (state_q == ST_WAIT) && iBURST_DONE && (port_q == PORT_WR);

    fb_addr_gen #(
        .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)
    ) u_rd_addr (
        .clk(iCLK), .rst_n(iRST_N), .vsync(iRD_VSYNC), .busy(rd_busy),
        .done(rd_done), .addr(rd_addr), .en(rd_en), .wrap(rd_wrap_unused)
    );

    fb_addr_gen #(
        .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)
    ) u_wr_addr (
        .clk(iCLK), .rst_n(iRST_N), .vsync(iWR_VSYNC), .busy(wr_busy),
        .done(wr_done), .addr(wr_addr), .en(wr_en), .wrap(wr_wrap)
    );

`ifdef FB_PINGPONG_EN
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, full_bank_q, full_bank_d;
    logic addr_msb_unused;

    // Bank tracking: writer flips per frame, reader follows last complete frame.
    always_comb begin
        wr_bank_d   = wr_bank_q ^ iWR_VSYNC;
        full_bank_d = wr_wrap ? wr_bank_q : full_bank_q;
        rd_bank_d   = iRD_VSYNC ? full_bank_q : rd_bank_q;
    end

    // Bank registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_bank_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_bank_q <= full_bank_d;
        end
    end

    assign oWR_BANK        = wr_bank_q;
    assign oRD_BANK        = rd_bank_q;
    assign wr_cmd_addr     = {wr_bank_q, wr_addr[ADDR_W-2:0]};
    assign rd_cmd_addr     = {rd_bank_q, rd_addr[ADDR_W-2:0]};
    assign addr_msb_unused = wr_addr[ADDR_W-1] ^ rd_addr[ADDR_W-1];
`else
    logic wrap_unused;
    assign wrap_unused = wr_wrap;
    assign oWR_BANK    = 1'b0;
    assign oRD_BANK    = 1'b0;
    assign wr_cmd_addr = wr_addr;
    assign rd_cmd_addr = rd_addr;
`endif

    // FSM next-state; command fields are latched at grant and held through WAIT.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        last_d     = last_q;
        cmd_addr_d = cmd_addr_q;
        unique case (state_q)
            ST_IDLE: if (grant) begin
                state_d    = ST_CMD;
                port_d     = grant_port;
                last_d     = grant_port;
                cmd_addr_d = (grant_port == PORT_WR) ? wr_cmd_addr : rd_cmd_addr;
            end
            ST_CMD:  if (iCMD_READY)  state_d = ST_WAIT;
            ST_WAIT: if (iBURST_DONE) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and command registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            port_q     <= PORT_RD;
            last_q     <= PORT_WR;
            cmd_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            last_q     <= last_d;
            cmd_addr_q <= cmd_addr_d;
        end
    end

    assign oCMD_VALID = (state_q == ST_CMD);
    assign oCMD_WRITE = port_q;
    assign oCMD_ADDR  = cmd_addr_q;
    assign oBUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Bench for frame_buf_arbiter (BURST_LEN=4, FRAME_WORDS=16, RD_DEPTH=16).
// Works in both builds; bank expectations follow FB_PINGPONG_EN.
module tb_frame_buf_arbiter;

    localparam int AW = 24, LW = 10, BL = 4, FW = 16, RD = 16;
`ifdef FB_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic          iCLK = 1'b0, iRST_N = 1'b0;
    logic [LW-1:0] iWR_LEVEL = '0, iRD_LEVEL = '0;
    logic          iWR_VSYNC = 1'b0, iRD_VSYNC = 1'b0;
    logic          iCMD_READY = 1'b0, iBURST_DONE = 1'b0;
    logic          oCMD_VALID, oCMD_WRITE, oBUSY, oWR_BANK, oRD_BANK;
    logic [AW-1:0] oCMD_ADDR;

    frame_buf_arbiter #(
        .ADDR_W(AW), .LVL_W(LW), .BURST_LEN(BL), .FRAME_WORDS(FW), .RD_DEPTH(RD)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iWR_LEVEL(iWR_LEVEL), .iRD_LEVEL(iRD_LEVEL),
        .iWR_VSYNC(iWR_VSYNC), .iRD_VSYNC(iRD_VSYNC), .oCMD_VALID(oCMD_VALID),
        .oCMD_WRITE(oCMD_WRITE), .oCMD_ADDR(oCMD_ADDR), .iCMD_READY(iCMD_READY),
        .iBURST_DONE(iBURST_DONE), .oBUSY(oBUSY), .oWR_BANK(oWR_BANK), .oRD_BANK(oRD_BANK)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0, errors = 0;

    // Reference model: frame position per port (0=read, 1=write), in words.
    int m_addr[2];
    bit m_en[2], m_pend[2];
    int m_last;
    bit m_wb, m_rb, m_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_addr = '{0, 0}; m_en = '{0, 0}; m_pend = '{0, 0};
        m_last = 1; m_wb = 0; m_rb = 0; m_fb = 0;
    endfunction

    function automatic void model_bank_vsync(int p);
        if (PP) begin
            if (p == 1) m_wb = ~m_wb;
            else        m_rb = m_fb;
        end
    endfunction

    function automatic void model_vsync(int p, bit busy);
        model_bank_vsync(p);
        if (busy) m_pend[p] = 1;
        else begin m_addr[p] = 0; m_en[p] = 1; end
    endfunction

    function automatic void model_done(int p, bit vs_now);
        if (vs_now) model_bank_vsync(p);
        if (vs_now || m_pend[p]) begin
            m_addr[p] = 0; m_en[p] = 1; m_pend[p] = 0;
        end else begin
            m_addr[p] += BL;
            if (m_addr[p] == FW) begin
                m_addr[p] = 0; m_en[p] = 0;
                if (p == 1) m_fb = m_wb;
            end
        end
    endfunction

    // -1: no grant, 0: read, 1: write
    function automatic int predict(int rdl, int wrl);
        bit re = m_en[0] && (RD - rdl >= BL);
        bit we = m_en[1] && (wrl >= BL);
        if (re && rdl < BL) return 0;
        if (re && we)       return 1 - m_last;
        if (re)             return 0;
        if (we)             return 1;
        return -1;
    endfunction

    function automatic logic [31:0] exp_addr(int p);
        logic [31:0] a = 32'(m_addr[p]);
        bit b = (p == 1) ? m_wb : m_rb;
        if (PP) a[AW-1] = b;
        return a;
    endfunction

    task automatic pulse_vs(int p, bit v);
        if (p == 1) iWR_VSYNC = v; else iRD_VSYNC = v;
    endtask

    // Vsync while idle, with levels that make neither port eligible.
    task automatic idle_vsync(int p);
        iRD_LEVEL = LW'(RD); iWR_LEVEL = '0;
        pulse_vs(p, 1);
        @(negedge iCLK);
        pulse_vs(p, 0);
        model_vsync(p, 0);
    endtask

    // One arbitration round starting in IDLE at a negedge.
    task automatic burst(input string tag, input int rdl, input int wrl, input int stall,
                         input int vs_mid, input bit vs_done);
        int p;
        logic [31:0] ea;
        iRD_LEVEL = LW'(rdl); iWR_LEVEL = LW'(wrl);
        p = predict(rdl, wrl);
        @(negedge iCLK);
        if (p < 0) begin
            chk({tag, ":no_grant"}, 32'(oCMD_VALID), 0);
            @(negedge iCLK);
            chk({tag, ":no_grant2"}, 32'(oBUSY), 0);
            return;
        end
        ea = exp_addr(p);
        m_last = p;
        chk({tag, ":valid"}, 32'(oCMD_VALID), 1);
        chk({tag, ":write"}, 32'(oCMD_WRITE), 32'(p));
        chk({tag, ":addr"},  32'(oCMD_ADDR), ea);
        for (int i = 0; i < stall; i++) begin
            @(negedge iCLK);
            chk({tag, ":stall_valid"}, 32'(oCMD_VALID), 1);
            chk({tag, ":stall_write"}, 32'(oCMD_WRITE), 32'(p));
            chk({tag, ":stall_addr"},  32'(oCMD_ADDR), ea);
        end
        iCMD_READY = 1;
        @(negedge iCLK);
        iCMD_READY = 0;
        chk({tag, ":wait_valid"}, 32'(oCMD_VALID), 0);
        chk({tag, ":wait_busy"},  32'(oBUSY), 1);
        if (vs_mid >= 0) begin
            pulse_vs(vs_mid, 1);
            @(negedge iCLK);
            pulse_vs(vs_mid, 0);
            model_vsync(vs_mid, vs_mid == p);
        end
        @(negedge iCLK);
        iBURST_DONE = 1;
        if (vs_done) pulse_vs(p, 1);
        @(negedge iCLK);
        iBURST_DONE = 0;
        if (vs_done) pulse_vs(p, 0);
        model_done(p, vs_done);
        chk({tag, ":idle"},    32'(oBUSY), 0);
        chk({tag, ":wr_bank"}, 32'(oWR_BANK), 32'(m_wb));
        chk({tag, ":rd_bank"}, 32'(oRD_BANK), 32'(m_rb));
    endtask

    task automatic do_reset();
        iRST_N = 0;
        #1;
        model_reset();
        chk("rst:valid", 32'(oCMD_VALID), 0);
        chk("rst:write", 32'(oCMD_WRITE), 0);
        chk("rst:addr",  32'(oCMD_ADDR), 0);
        chk("rst:busy",  32'(oBUSY), 0);
        chk("rst:wbank", 32'(oWR_BANK), 0);
        chk("rst:rbank", 32'(oRD_BANK), 0);
        @(negedge iCLK);
        iRST_N = 1;
        @(negedge iCLK);
    endtask

    initial begin
        int guard;
        @(negedge iCLK);
        do_reset();

        // Read frame from an empty display FIFO: 0,4,8,12 then stop.
        idle_vsync(0);
        for (int i = 0; i < 4; i++) burst("rd_frame", 0, 0, 0, -1, 0);
        burst("rd_frame_end", 0, 0, 0, -1, 0);

        // Alternation from reset: read wins the first tie.
        do_reset();
        idle_vsync(0);
        idle_vsync(1);
        for (int i = 0; i < 4; i++) begin
            burst("alt", 8, 8, 0, -1, 0);
            chk("alt:order", 32'(m_last), 32'(i % 2));
        end

        // Underflow guard: read last, then low read level beats eligible write.
        burst("uf_pre", 8, 0, 0, -1, 0);
        burst("uf_guard", 2, 8, 0, -1, 0);

        // Long command stall.
        idle_vsync(0);
        burst("stall5", 8, 8, 5, -1, 0);

        // Write vsync during WAIT at address 8 restarts at 0.
        idle_vsync(1);
        guard = 0;
        while (m_addr[1] != 8 && guard < 4) begin
            burst("wr_adv", 16, 8, 0, -1, 0);
            guard++;
        end
        chk("vs_wait:at8", 32'(m_addr[1]), 8);
        burst("vs_wait", 16, 8, 1, 1, 0);
        burst("vs_wait_next", 16, 8, 0, -1, 0);

        // Vsync coinciding with burst done wins over the advance.
        burst("vs_done", 16, 8, 0, -1, 0);
        burst("vs_done_hit", 16, 8, 0, -1, 1);
        burst("vs_done_next", 16, 8, 0, -1, 0);

        // Ping-pong sequence: two complete write frames, then vsyncs.
        do_reset();
        for (int f = 0; f < 2; f++) begin
            idle_vsync(1);
            for (int i = 0; i < 4; i++) burst("wr_frame", 16, 8, 0, -1, 0);
            burst("wr_frame_end", 16, 8, 0, -1, 0);
        end
        idle_vsync(1);
        idle_vsync(0);
        chk("pp:wbank", 32'(oWR_BANK), 32'(m_wb));
        chk("pp:rbank", 32'(oRD_BANK), 32'(m_rb));
`ifdef FB_PINGPONG_EN
        chk("pp:wbank1", 32'(oWR_BANK), 1);
        chk("pp:rbank0", 32'(oRD_BANK), 0);
`endif
        burst("pp_read", 8, 0, 0, -1, 0);

        // Stray burst-done in IDLE is ignored.
        iRD_LEVEL = LW'(RD); iWR_LEVEL = '0;
        iBURST_DONE = 1;
        @(negedge iCLK);
        iBURST_DONE = 0;
        burst("stray_done", 8, 0, 0, -1, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 2) idle_vsync(r);
            burst("rand", $urandom_range(0, 16), $urandom_range(0, 12), $urandom_range(0, 4),
                  ($urandom_range(0, 5) < 2) ? int'($urandom_range(0, 1)) : -1,
                  $urandom_range(0, 7) == 0);
        end

        // Reset mid-burst abandons everything, enables included.
        idle_vsync(0);
        iRD_LEVEL = 8; iWR_LEVEL = 8;
        @(negedge iCLK);
        iCMD_READY = 1;
        @(negedge iCLK);
        iCMD_READY = 0;
        chk("mid_rst:busy_before", 32'(oBUSY), 1);
        #2 iRST_N = 0;
        #1;
        chk("mid_rst:busy", 32'(oBUSY), 0);
        chk("mid_rst:valid", 32'(oCMD_VALID), 0);
        model_reset();
        @(negedge iCLK);
        iRST_N = 1;
        burst("post_rst", 8, 8, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
